// File: rtl/sonic_motion_ctrl_pkg.sv
// Shared types and sprite-sheet geometry for the Sonic motion controller.
package sonic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_JUMP = 2'd2
  } state_e;

  localparam int FRAME_W    = 18;
  localparam int FRAME_H    = 32;
  localparam int RUN_ROW_Y  = 0;
  localparam int JUMP_ROW_Y = 32;
  localparam int SHEET_W    = 360;

  // Run frames skip column 0, which holds the standing pose.
  function automatic logic [9:0] frame_x(input state_e s, input logic [1:0] anim);
    case (s)
      ST_RUN:  frame_x = 10'(FRAME_W * (32'(anim) + 1));
      ST_JUMP: frame_x = 10'(FRAME_W * 32'(anim));
      default: frame_x = 10'd0;
    endcase
  endfunction

  function automatic logic [9:0] frame_y(input state_e s);
    frame_y = (s == ST_JUMP) ? 10'(JUMP_ROW_Y) : 10'(RUN_ROW_Y);
  endfunction

endpackage

// File: rtl/sonic_motion_ctrl_if.sv
// Key inputs, frame tick and renderer-facing outputs of the motion controller.
interface sonic_motion_ctrl_if;
  logic       frame_tick;
  logic       key_right;
  logic       key_jump;
  logic [9:0] sprite_offset_x;
  logic [9:0] sprite_offset_y;
  logic [9:0] jump_pos_y;
  logic [9:0] position;
  logic [1:0] state_o;

  modport slave (
    input  frame_tick, key_right, key_jump,
    output sprite_offset_x, sprite_offset_y, jump_pos_y, position, state_o
  );

  modport master (
    output frame_tick, key_right, key_jump,
    input  sprite_offset_x, sprite_offset_y, jump_pos_y, position, state_o
  );
endinterface

// File: rtl/sonic_motion_ctrl_jump_physics.sv
// Integer jump ballistics: height and velocity registers plus landing detect.
module sonic_jump_physics #(
  parameter int JUMP_V0 = 12
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       i_tick,
  input  logic       i_start,
  input  logic       i_active,
  output logic       o_landed,
  output logic [9:0] o_jump_pos
);

  logic signed [5:0]  r_vel;
  logic        [9:0]  r_pos;
  logic signed [10:0] w_sum;

  // Sum is widened so a descending step past ground reads as non-positive.
  assign w_sum      = $signed({1'b0, r_pos}) + $signed({{5{r_vel[5]}}, r_vel});
  assign o_landed   = i_active && (w_sum <= 11'sd0);
  assign o_jump_pos = r_pos;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vel <= '0;
      r_pos <= '0;
    end else if (i_tick) begin
      if (i_start) begin
        r_vel <= 6'(JUMP_V0);
        r_pos <= '0;
      end else if (i_active) begin
        if (o_landed) begin
          r_vel <= '0;
          r_pos <= '0;
        end else begin
          r_vel <= r_vel - 6'sd1;
          r_pos <= w_sum[9:0];
        end
      end
    end
  end

endmodule

// File: rtl/sonic_motion_ctrl.sv
// Per-frame player motion: IDLE/RUN/JUMP FSM, world scroll, animation and sprite select.
module sonic_motion_ctrl
  import sonic_pkg::*;
#(
  parameter int ANIM_DIV  = 4,
  parameter int RUN_SPEED = 2,
  parameter int POS_MAX   = 1000,
  parameter int JUMP_V0   = 12
) (
  input logic                vga_clk,
  input logic                reset_n,
  sonic_motion_ctrl_if.slave bus
);

  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  state_e             r_state, w_next;
  logic               w_start, w_landed, w_chg, w_tick;
  logic [9:0]         w_jump_pos;
  logic [9:0]         r_position, w_position_next;
  logic [10:0]        w_pos_sum;
  logic [DIV_W-1:0]   r_div, w_div_base, w_div_next;
  logic [1:0]         r_anim, w_anim_base, w_anim_next;
  logic [9:0]         r_off_x, r_off_y;

  assign w_tick = bus.frame_tick;

  sonic_jump_physics #(.JUMP_V0(JUMP_V0)) u_phys (
    .vga_clk   (vga_clk),
    .reset_n   (reset_n),
    .i_tick    (w_tick),
    .i_start   (w_start),
    .i_active  (r_state == ST_JUMP),
    .o_landed  (w_landed),
    .o_jump_pos(w_jump_pos)
  );

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    if (w_tick) begin
      case (r_state)
        ST_IDLE, ST_RUN: begin
          if (bus.key_jump) begin
            w_next  = ST_JUMP;
            w_start = 1'b1;
          end else if (bus.key_right) begin
            w_next = ST_RUN;
          end else begin
            w_next = ST_IDLE;
          end
        end
        ST_JUMP: if (w_landed) w_next = bus.key_right ? ST_RUN : ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  assign w_pos_sum       = {1'b0, r_position} + 11'(RUN_SPEED);
  assign w_position_next = (w_pos_sum > 11'(POS_MAX)) ? 10'(POS_MAX) : w_pos_sum[9:0];

  // The entering tick counts as the first tick of the new state's animation cycle.
  always_comb begin
    w_chg       = (w_next != r_state);
    w_div_base  = w_chg ? '0 : r_div;
    w_anim_base = w_chg ? '0 : r_anim;
    w_div_next  = w_div_base;
    w_anim_next = w_anim_base;
    if (w_next != ST_IDLE) begin
      if (w_div_base == DIV_W'(ANIM_DIV - 1)) begin
        w_div_next  = '0;
        w_anim_next = w_anim_base + 2'd1;
      end else begin
        w_div_next = w_div_base + 1'b1;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_position <= '0;
      r_div      <= '0;
      r_anim     <= '0;
      r_off_x    <= '0;
      r_off_y    <= '0;
    end else if (w_tick) begin
      if (w_next == ST_RUN || (w_next == ST_JUMP && bus.key_right))
        r_position <= w_position_next;
      r_div   <= w_div_next;
      r_anim  <= w_anim_next;
      r_off_x <= frame_x(w_next, w_anim_next);
      r_off_y <= frame_y(w_next);
    end
  end

  assign bus.sprite_offset_x = r_off_x;
  assign bus.sprite_offset_y = r_off_y;
  assign bus.jump_pos_y      = w_jump_pos;
  assign bus.position        = r_position;
  assign bus.state_o         = r_state;

endmodule

// File: doc/sonic_motion_ctrl.md
# sonic_motion_ctrl

Per-frame player-motion controller that produces the sprite-selection and placement values consumed by the Sonic sprite renderer: sprite-sheet frame offsets, jump height above ground, and horizontal world scroll position. Reads the player keys once per video frame, runs an IDLE/RUN/JUMP state machine with integer jump physics and animation counters, and holds all outputs stable between frame ticks.

## Interface
- ANIM_DIV, 4: frame ticks per animation-frame advance
- RUN_SPEED, 2: world-scroll pixels added per frame tick while moving
- POS_MAX, 1000: saturation limit of `position`
- JUMP_V0, 12: initial upward velocity, px/frame

Ports:
- vga_clk  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per frame, asserted at start of vertical blank
- key_right  in  1  run-right key, level
- key_jump  in  1  jump key, level
- sprite_offset_x  out  10  sheet-pixel X offset of current Sonic frame
- sprite_offset_y  out  10  sheet-pixel Y offset of current Sonic frame
- jump_pos_y  out  10  height above ground, screen pixels, unsigned
- position  out  10  world scroll position
- state_o  out  2  current state, debug

## Operation
- All state changes occur only on cycles with `frame_tick`=1; otherwise every register holds.
- States: IDLE (0), RUN (1), JUMP (2).
- IDLE/RUN at tick, priority order: `key_jump`=1 -> JUMP, vel=JUMP_V0, jump_pos unchanged (0); else `key_right`=1 -> RUN; else IDLE. Jump is level-sensitive: holding `key_jump` re-jumps on the landing-following tick.
- JUMP at tick: if jump_pos+vel <= 0 -> jump_pos=0, vel=0, next state RUN if `key_right` else IDLE; else jump_pos += vel, vel -= 1. `key_jump` ignored in JUMP.
- vel is 6-bit signed, range -12..+12; sum computed 11-bit signed before compare.
- Scroll: in RUN, or JUMP with `key_right`=1, position = min(position+RUN_SPEED, POS_MAX). Never decrements.
- Animation: div counter counts ticks 0..ANIM_DIV-1; on wrap, anim_idx (2 bits) increments, 3 wraps to 0. Both cleared on any state change; hold in IDLE.
- Sprite select, sheet units (FRAME_W=18, FRAME_H=32): IDLE -> (0,0); RUN -> (18*(anim_idx+1), 0); JUMP -> (18*anim_idx, 32).
- Offsets are computed from next-state values, so offsets, jump_pos_y and state_o always agree in the same cycle.

## Timing
- Reset (async assert, sync release): state IDLE, all outputs 0, vel 0, counters 0.
- Latency: outputs update on the vga_clk edge that samples `frame_tick`; visible the following cycle; stable for the rest of the frame.
- Jump trajectory with JUMP_V0=12: entry tick pos 0; ticks 1..12 -> 12,23,...,78; tick 13 -> 78; ticks 14..24 descend to 12; tick 25 lands at 0 and exits JUMP.
- Reset mid-jump: immediate return to IDLE, jump_pos_y 0.
- `frame_tick` on consecutive cycles is legal; each cycle is a full update.
- Keys are sampled only at the tick; changes between ticks have no effect.

## Structure
- Shared package `sonic_pkg`: state enum, FRAME_W, FRAME_H, RUN_ROW_Y=0, JUMP_ROW_Y=32, sheet width 360.
- One sub-module, `sonic_jump_physics`: vel/jump_pos registers, landing detect, `landed` pulse back to the FSM.
- Top holds FSM, scroll accumulator, animation counters, sprite-select register.

## Test plan
- Reset then ticks with no keys -> state_o 0, all outputs 0 indefinitely.
- key_right held for 8 ticks -> state RUN, position 16, anim_idx 1 after tick 4 so sprite_offset_x 36, sprite_offset_y 0, then 54 after tick 8.
- key_jump pulsed at one tick -> jump_pos_y 78 at tick 12 and 13, 0 at tick 25, state IDLE, offset_y 32 throughout JUMP.
- key_right held with position starting at 999 -> position 1000 after next tick, stays 1000.
- reset_n asserted at tick 6 of a jump, between clock edges -> all outputs 0 without a clock edge; IDLE after release.
- key_jump and key_right both held from IDLE -> JUMP wins; position advances 2 per tick during jump; after landing state RUN, immediately re-enters JUMP on the next tick.
